mem_stage: RTL

// - Memory-access pipeline stage between EX_stage and WB_stage of the LoongArch 5-stage core.
// - Waits for the data_sram data_ok response of loads/stores EX already issued (addr_ok accepted).
// - Extracts and extends load data, then packs to_WB_data for WB.
// - Drops stale responses of requests killed by a WB exception/ertn flush.

---
 rtl/mem_stage_pkg.sv | 45 ++++
 rtl/mem_load_align.sv | 36 +++
 rtl/mem_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, load_op bit indices, FSM states and EX payload layout for mem_stage
package mem_stage_pkg;

    localparam int CSR_NUM_W = 14;
    localparam int RJ_W      = 5;

    // EX -> MEM payload, WB-facing payload and forwarding bus widths
    localparam int TO_MEM_W  = 32 + 5 + 32 + 1 + 1 + 5 + 6 + 1 + 1 + CSR_NUM_W + 32 + RJ_W;
    localparam int TO_WB_W   = 32 + 5 + 32 + 1 + 6 + 1 + 1 + CSR_NUM_W + 32 + RJ_W;
    localparam int MEM_FWD_W = 5 + 32 + 1 + 1;

    // one-hot load_op bit positions; all-zero means store or no load
    localparam int LD_B  = 0;
    localparam int LD_BU = 1;
    localparam int LD_H  = 2;
    localparam int LD_HU = 3;
    localparam int LD_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic [4:0]           dest;
        logic [31:0]          alu_result;
        logic                 gr_we;
        logic                 mem_req;
        logic [4:0]           load_op;
        logic                 ex_int;
        logic                 ex_sys;
        logic                 ex_brk;
        logic                 ex_adef;
        logic                 ex_adem;
        logic                 ex_ine;
        logic                 is_etrn;
        logic                 op_csr;
        logic [CSR_NUM_W-1:0] csr_num;
        logic [31:0]          csr_wmask;
        logic [RJ_W-1:0]      rj;
    } mem_in_t;

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - byte/half/word extraction and extension of load response data
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [4:0]  load_op,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // pick the addressed byte/half lane, then extend according to the load kind
    always_comb begin
        byte_sel  = rdata[7:0];
        half_sel  = addr[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (addr)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        if (load_op[LD_B]) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (load_op[LD_BU]) begin
            load_data = {24'b0, byte_sel};
        end else if (load_op[LD_H]) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (load_op[LD_HU]) begin
            load_data = {16'b0, half_sel};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: waits for data_ok, aligns load data, drops stale responses after flush
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DISCARD_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [TO_MEM_W-1:0]  to_MEM_data,
    input  logic                 EX_to_MEM_valid,
    output logic                 MEM_allow_in,
    input  logic                 EX_req_outstanding,
    output logic [TO_WB_W-1:0]   to_WB_data,
    output logic                 MEM_to_WB_valid,
    input  logic                 WB_allow_in,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 wb_ex,
    output logic                 MEM_ex,
    output logic [MEM_FWD_W-1:0] MEM_forward
);

    localparam logic [DISCARD_W:0] CNT_MAX = {1'b0, {DISCARD_W{1'b1}}};

    mem_in_t              ex_in;
    mem_in_t              mem_r;
    logic                 MEM_valid;
    mem_state_t           state;
    mem_state_t           state_nx;
    logic [31:0]          rdata_buf;
    logic [DISCARD_W-1:0] discard_cnt;

    logic                 cnt_zero;
    logic                 resp_live;
    logic                 MEM_ready_go;
    logic                 kill_wait;
    logic [DISCARD_W:0]   cnt_inc;
    logic [DISCARD_W:0]   cnt_dec;
    logic [DISCARD_W:0]   cnt_sum;
    logic [31:0]          rdata_sel;
    logic [31:0]          load_data;
    logic [31:0]          final_result;
    logic                 load_pending;

    assign ex_in = mem_in_t'(to_MEM_data);

    // a response belongs to the current instruction only once all stale ones are drained
    assign cnt_zero     = (discard_cnt == '0);
    assign resp_live    = data_sram_data_ok & cnt_zero;
    assign MEM_ready_go = ~mem_r.mem_req | (state == ST_DONE) | ((state == ST_WAIT) & resp_live);
    assign MEM_allow_in = ~MEM_valid | (MEM_ready_go & WB_allow_in);

    // each flush orphans the request MEM is still waiting on plus any EX already had accepted
    assign kill_wait = (state == ST_WAIT) & ~resp_live;
    assign cnt_inc   = wb_ex ? ({{DISCARD_W{1'b0}}, kill_wait} + {{DISCARD_W{1'b0}}, EX_req_outstanding})
                             : '0;
    assign cnt_dec   = {{DISCARD_W{1'b0}}, data_sram_data_ok & ~cnt_zero};
    assign cnt_sum   = {1'b0, discard_cnt} + cnt_inc - cnt_dec;

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state: flush wins, then accept, then a buffered completion while WB stalls
    always_comb begin
        state_nx = state;
        if (wb_ex) begin
            state_nx = ST_IDLE;
        end else if (MEM_allow_in) begin
            state_nx = (EX_to_MEM_valid & ex_in.mem_req) ? ST_WAIT : ST_IDLE;
        end else if ((state == ST_WAIT) & resp_live) begin
            state_nx = ST_DONE;
        end
    end

    // valid bit and payload capture on accept; flush overrides a same-cycle accept
    always_ff @(posedge clk) begin
        if (reset) begin
            MEM_valid <= 1'b0;
            mem_r     <= '0;
        end else begin
            if (wb_ex) begin
                MEM_valid <= 1'b0;
            end else if (MEM_allow_in) begin
                MEM_valid <= EX_to_MEM_valid;
            end
            if (MEM_allow_in & EX_to_MEM_valid) begin
                mem_r <= ex_in;
            end
        end
    end

    // hold the live response so a WB stall can replay it
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_buf <= '0;
        end else if ((state == ST_WAIT) & resp_live) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    // stale-response counter, saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= '0;
        end else if (cnt_sum > CNT_MAX) begin
            discard_cnt <= CNT_MAX[DISCARD_W-1:0];
        end else begin
            discard_cnt <= cnt_sum[DISCARD_W-1:0];
        end
    end

    // more outstanding kills than the counter can track means responses would be misattributed
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (cnt_sum <= CNT_MAX);
        end
    end

    assign rdata_sel = (state == ST_DONE) ? rdata_buf : data_sram_rdata;

    mem_load_align u_align (
        .rdata     (rdata_sel),
        .addr      (mem_r.alu_result[1:0]),
        .load_op   (mem_r.load_op),
        .load_data (load_data)
    );

    assign final_result = (|mem_r.load_op) ? load_data : mem_r.alu_result;

    assign MEM_to_WB_valid = MEM_valid & MEM_ready_go & ~wb_ex;

    assign to_WB_data = {mem_r.pc, mem_r.dest, final_result, mem_r.gr_we,
                         mem_r.ex_int, mem_r.ex_sys, mem_r.ex_brk, mem_r.ex_adef, mem_r.ex_adem, mem_r.ex_ine,
                         mem_r.is_etrn, mem_r.op_csr, mem_r.csr_num, mem_r.csr_wmask, mem_r.rj};

    assign MEM_ex = MEM_valid & (mem_r.ex_int | mem_r.ex_sys | mem_r.ex_brk | mem_r.ex_adef |
                                 mem_r.ex_adem | mem_r.ex_ine | mem_r.is_etrn);

    assign load_pending = MEM_valid & (|mem_r.load_op) & ~MEM_ready_go;

    assign MEM_forward = {mem_r.dest & {5{MEM_valid & mem_r.gr_we}}, final_result,
                          MEM_valid & mem_r.op_csr, load_pending};

endmodule
